// File: rtl/chiptune_pkg.sv
// Shared types and constants for the APU register sequencer.
package chiptune_pkg;

  localparam int unsigned REG_COUNT = 16;
  localparam logic [3:0] HDR_NIBBLE = 4'h8;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } reg_pkt_t;

  typedef enum logic {
    StHdr,
    StDat
  } parse_state_e;

endpackage

// File: rtl/reg_fifo.sv
// Synchronous FIFO of register-write packets; a push on full succeeds only with a same-cycle pop.
module reg_fifo
  import chiptune_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  reg_pkt_t   wdata_i,
  input  logic       pop_i,
  output reg_pkt_t   rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [4:0] level_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  reg_pkt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      level_q;
  logic            do_push, do_pop;

  assign full_o  = (level_q == 5'(DEPTH));
  assign empty_o = (level_q == 5'd0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage carries no reset; occupancy is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 5'd1;
        2'b01:   level_q <= level_q - 5'd1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_sequencer.sv
// Serial header/data parser feeding a write queue that updates sixteen APU registers.
// Optional REG_SEQ_FRAME_SYNC_EN: hold queued writes until frame_tick, then drain back-to-back.
module reg_sequencer
  import chiptune_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 4800
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         frame_tick,
  output logic [127:0] reg_data,
  output logic [3:0]   reg_event,
  output logic         overflow,
  output logic [4:0]   level
);

  localparam int unsigned TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  parse_state_e                 state_q, state_d;
  logic [3:0]                   addr_q, addr_d;
  logic [TW-1:0]                tmo_q, tmo_d;
  logic [REG_COUNT-1:0][7:0]    regs_q;
  logic [3:0]                   event_q;
  logic                         ovf_q;

  logic       push, pop, drain_en, full, empty;
  reg_pkt_t   push_pkt, pop_pkt;
  logic [4:0] fifo_level;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    push    = 1'b0;
    unique case (state_q)
      StHdr: begin
        if (rx_valid && rx_data[7:4] == HDR_NIBBLE) begin
          addr_d  = rx_data[3:0];
          tmo_d   = '0;
          state_d = StDat;
        end
      end
      StDat: begin
        if (rx_valid) begin
          push    = 1'b1;
          state_d = StHdr;
        end else if (tmo_q == TmoLast) begin
          tmo_d   = '0;
          state_d = StHdr;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StHdr;
      addr_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign push_pkt = '{addr: addr_q, data: rx_data};
  assign pop      = drain_en && !empty;

`ifdef REG_SEQ_FRAME_SYNC_EN
  logic drain_q, drain_d, becomes_empty;

  // Level 1 is never full, so a concurrent push is always accepted and keeps the queue non-empty.
  assign becomes_empty = pop && (fifo_level == 5'd1) && !push;

  always_comb begin
    drain_d = drain_q;
    if (frame_tick) begin
      drain_d = 1'b1;
    end else if (empty || becomes_empty) begin
      drain_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drain_q <= 1'b0;
    else        drain_q <= drain_d;
  end

  assign drain_en = drain_q;
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign drain_en          = 1'b1;
`endif

  reg_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_pkt),
    .pop_i   (pop),
    .rdata_o (pop_pkt),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q  <= '0;
      event_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      event_q <= '0;
      if (pop) begin
        regs_q[pop_pkt.addr]       <= pop_pkt.data;
        event_q[pop_pkt.addr[3:2]] <= 1'b1;
      end
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign reg_data  = regs_q;
  assign reg_event = event_q;
  assign overflow  = ovf_q;
  assign level     = fifo_level;

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed self-checking bench for reg_sequencer; frame-sync cases run when REG_SEQ_FRAME_SYNC_EN is set.
module tb_reg_sequencer;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic [7:0]   rx_data    = 8'h00;
  logic         rx_valid   = 1'b0;
  logic         frame_tick = 1'b0;
  logic [127:0] reg_data;
  logic [3:0]   reg_event;
  logic         overflow;
  logic [4:0]   level;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_regs [16];

  always #5 clk = ~clk;

  reg_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_tick (frame_tick),
    .reg_data   (reg_data),
    .reg_event  (reg_event),
    .overflow   (overflow),
    .level      (level)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = exp_regs[i];
    return f;
  endfunction

  // Caller sits at a negedge; the byte is sampled at the next posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_pkt(input logic [3:0] a, input logic [7:0] d);
    send_byte({4'h8, a});
    send_byte(d);
  endtask

  // Called at the negedge after the push edge; the pop lands on the next edge.
  task automatic expect_write(input string tag, input logic [3:0] a, input logic [7:0] d);
    logic [3:0] ev;
    @(negedge clk);
    exp_regs[a] = d;
    ev = 4'b0001 << a[3:2];
    check_eq({tag, "_regs"}, reg_data, exp_flat());
    check_eq({tag, "_event"}, {124'd0, reg_event}, {124'd0, ev});
    @(negedge clk);
    check_eq({tag, "_event_clr"}, {124'd0, reg_event}, 128'd0);
  endtask

  initial begin
    logic [3:0] ev;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
`ifdef REG_SEQ_FRAME_SYNC_EN
    frame_tick = 1'b1;  // keep draining enabled for the ordinary cases
`endif
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check_eq("rst_regs", reg_data, 128'd0);
    check_eq("rst_event", {124'd0, reg_event}, 128'd0);
    check_eq("rst_ovf", {127'd0, overflow}, 128'd0);
    check_eq("rst_level", {123'd0, level}, 128'd0);

    // Header 0x82, data 0x3F: queued one edge, applied the next.
    write_pkt(4'h2, 8'h3F);
    check_eq("nobypass_level", {123'd0, level}, 128'd1);
    check_eq("nobypass_regs", reg_data, 128'd0);
    expect_write("hdr82", 4'h2, 8'h3F);
    check_eq("hdr82_level", {123'd0, level}, 128'd0);

    // Non-header byte ignored, then register 11.
    send_byte(8'h55);
    write_pkt(4'hB, 8'h12);
    expect_write("reg11", 4'hB, 8'h12);

    // Header then timeout; trailing byte must not be taken as data.
    send_byte(8'h8C);
    idle(TIMEOUT + 1);
    send_byte(8'h40);
    check_eq("tmo_level", {123'd0, level}, 128'd0);
    idle(3);
    check_eq("tmo_regs", reg_data, exp_flat());
    check_eq("tmo_event", {124'd0, reg_event}, 128'd0);
    write_pkt(4'h3, 8'h77);
    expect_write("after_tmo", 4'h3, 8'h77);

    // Gap shorter than the timeout is accepted.
    send_byte(8'h84);
    idle(5);
    send_byte(8'h21);
    expect_write("short_gap", 4'h4, 8'h21);

    // Back-to-back writes to one address keep the last value.
    write_pkt(4'h0, 8'h11);
    expect_write("rep_a", 4'h0, 8'h11);
    write_pkt(4'hF, 8'hE1);
    expect_write("grp3", 4'hF, 8'hE1);
    write_pkt(4'h0, 8'h22);
    expect_write("rep_b", 4'h0, 8'h22);

    // Reset right after a header drops everything, including the header.
    send_byte(8'h81);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    check_eq("mid_rst_regs", reg_data, 128'd0);
    check_eq("mid_rst_event", {124'd0, reg_event}, 128'd0);
    check_eq("mid_rst_level", {123'd0, level}, 128'd0);
    send_byte(8'h99);
    check_eq("mid_rst_hdr_gone", {123'd0, level}, 128'd0);
    idle(3);
    check_eq("mid_rst_99", reg_data, 128'd0);
    write_pkt(4'h1, 8'h99);
    expect_write("post_rst", 4'h1, 8'h99);

`ifdef REG_SEQ_FRAME_SYNC_EN
    frame_tick = 1'b0;
    idle(3);
    for (int i = 0; i < 9; i++) write_pkt(4'(i), 8'hA0 + 8'(i));
    check_eq("fs_level_full", {123'd0, level}, 128'd8);
    check_eq("fs_ovf", {127'd0, overflow}, 128'd1);
    check_eq("fs_held", reg_data, exp_flat());
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_regs[k] = 8'hA0 + 8'(k);
      ev = (k < 4) ? 4'b0001 : 4'b0010;
      check_eq($sformatf("fs_regs%0d", k), reg_data, exp_flat());
      check_eq($sformatf("fs_event%0d", k), {124'd0, reg_event}, {124'd0, ev});
      check_eq($sformatf("fs_level%0d", k), {123'd0, level}, 128'(7 - k));
    end
    @(negedge clk);
    check_eq("fs_event_clr", {124'd0, reg_event}, 128'd0);
    check_eq("fs_ninth_dropped", reg_data, exp_flat());
    write_pkt(4'hC, 8'h5A);
    idle(3);
    check_eq("fs_hold_again", {123'd0, level}, 128'd1);
    check_eq("fs_hold_regs", reg_data, exp_flat());
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    expect_write("fs_second", 4'hC, 8'h5A);
`else
    check_eq("no_ovf", {127'd0, overflow}, 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
